// File: rtl/apb4_slave_if.sv
// APB4 completer backed by a word-addressed register memory with byte-strobed writes.
// Optional wait states per access: define APB_WAIT_STATE_EN (WAIT_CYCLES per access).
module apb4_slave_if #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic                    PREADY,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PSLVERR
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned WORD_W = ADDR_WIDTH - 2;
    localparam int unsigned IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    // SETUP means a setup phase has been captured; the following cycle is the first access cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [STRB_W-1:0]     strb_q;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  setup_phase;
    logic                  ready_int;
    logic                  proto_err;
    logic                  complete;
    logic                  access_err;
    logic                  do_write;
    logic [WORD_W-1:0]     word_idx;
    logic [IDX_W-1:0]      mem_idx;

    assign setup_phase = PSEL & ~PENABLE;
    assign word_idx    = addr_q[ADDR_WIDTH-1:2];
    assign mem_idx     = word_idx[IDX_W-1:0];
    assign access_err  = (addr_q[1:0] != 2'b00)
                       | (word_idx >= WORD_W'(MEM_DEPTH))
                       | (~write_q & (strb_q != '0));
    assign do_write    = complete & write_q & ~access_err;

`ifdef APB_WAIT_STATE_EN
    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    logic [CNT_W-1:0] wait_cnt;

    // First access cycle counts as one wait, so the counter loads WAIT_CYCLES-1.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wait_cnt <= '0;
        end else if ((state_q == SETUP) && PSEL && PENABLE && !ready_int) begin
            wait_cnt <= CNT_W'(WAIT_CYCLES - 1);
        end else if ((state_q == ACCESS) && (wait_cnt != '0)) begin
            wait_cnt <= wait_cnt - CNT_W'(1);
        end
    end

    always_comb begin
        ready_int = (WAIT_CYCLES == 0);
        if (state_q == ACCESS) begin
            ready_int = (wait_cnt == '0);
        end
    end
`else
    localparam int unsigned UNUSED_WAIT_CYCLES = WAIT_CYCLES;

    assign ready_int = 1'b1;
`endif

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Address and control are frozen at the setup phase.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            strb_q  <= '0;
        end else if (setup_phase) begin
            addr_q  <= PADDR;
            write_q <= PWRITE;
            strb_q  <= PSTRB;
        end
    end

    always_comb begin
        state_d   = state_q;
        proto_err = 1'b0;
        complete  = 1'b0;
        case (state_q)
            IDLE: begin
                if (setup_phase) begin
                    state_d = SETUP;
                end else if (PSEL && PENABLE) begin
                    proto_err = 1'b1;
                end
            end
            SETUP, ACCESS: begin
                if (!PSEL) begin
                    state_d = IDLE;
                end else if (setup_phase) begin
                    state_d = SETUP;
                end else if (ready_int) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end else begin
                    state_d = ACCESS;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        PRDATA  = '0;
        if (!PRESET) begin
            PREADY  = proto_err | complete;
            PSLVERR = proto_err | (complete & access_err);
            if (complete && !write_q && !access_err) begin
                PRDATA = mem[mem_idx];
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_write) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (strb_q[b]) begin
                    mem[mem_idx][8*b +: 8] <= PWDATA[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_apb4_slave_if.sv
// Self-checking bench for apb4_slave_if: directed scenarios plus randomized traffic
// checked against an array-based memory model.
module tb_apb4_slave_if;

`ifdef APB_WAIT_STATE_EN
    localparam int EXP_WAIT = 2;
`else
    localparam int EXP_WAIT = 0;
`endif

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } op_t;

    logic        PCLK;
    logic        PRESET;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic        PSLVERR;

    int errors = 0;
    int checks = 0;

    logic [31:0] model_mem [256];

    apb4_slave_if #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .MEM_DEPTH  (256),
        .WAIT_CYCLES(2)
    ) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .PSEL   (PSEL),
        .PENABLE(PENABLE),
        .PWRITE (PWRITE),
        .PADDR  (PADDR),
        .PWDATA (PWDATA),
        .PSTRB  (PSTRB),
        .PREADY (PREADY),
        .PRDATA (PRDATA),
        .PSLVERR(PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Reference: legal word accesses hit a plain array; anything illegal errors with no effect.
    function automatic void model_xfer(input op_t op, output logic [31:0] exp_rdata,
                                       output logic exp_err);
        exp_err   = (op.addr[1:0] != 2'b00) || ((op.addr >> 2) >= 256) ||
                    (!op.wr && op.strb != 4'h0);
        exp_rdata = 32'h0;
        if (!exp_err) begin
            if (op.wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (op.strb[b]) model_mem[op.addr[9:2]][8*b +: 8] = op.data[8*b +: 8];
                end
            end else begin
                exp_rdata = model_mem[op.addr[9:2]];
            end
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 256; i++) model_mem[i] = 32'h0;
    endfunction

    // One APB transfer; returns at the falling edge of the completion cycle.
    task automatic xfer(input op_t op, input logic scramble, output logic [31:0] rdata,
                        output logic slverr, output int waits, output logic timeout,
                        output logic setup_rdy);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = op.wr;
        PADDR = op.addr; PWDATA = op.data; PSTRB = op.strb;
        @(negedge PCLK);
        setup_rdy = PREADY;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        if (scramble) begin
            PADDR  = $urandom;
            PWRITE = ~op.wr;
            PSTRB  = 4'($urandom);
        end
        waits = 0; timeout = 1'b1; rdata = 32'hx; slverr = 1'bx;
        for (int i = 0; i < 16; i++) begin
            @(negedge PCLK);
            if (PREADY === 1'b1) begin
                rdata = PRDATA; slverr = PSLVERR; timeout = 1'b0;
                break;
            end
            waits++;
            @(posedge PCLK); #1;
        end
    endtask

    task automatic bus_idle();
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic test_reset();
        op_t op;
        logic [31:0] rd, er; logic se, ee, to, sr; int wt;
        PRESET = 1'b1; PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0;
        PADDR = 32'h0; PWDATA = 32'h0; PSTRB = 4'h0;
        for (int c = 0; c < 3; c++) begin
            @(negedge PCLK);
            checks++;
            if ({PREADY, PSLVERR, PRDATA} !== 34'h0) begin
                errors++;
                $display("FAIL reset_outputs: cycle %0d ready=%b slverr=%b rdata=%h, need 0/0/0",
                         c, PREADY, PSLVERR, PRDATA);
            end
        end
        @(posedge PCLK); #1;
        PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        model_reset();
        op = '{wr: 1'b0, addr: 32'h0, data: 32'h0, strb: 4'h0};
        xfer(op, 1'b0, rd, se, wt, to, sr);
        model_xfer(op, er, ee);
        checks++;
        if (to || sr !== 1'b0 || wt != EXP_WAIT || se !== ee || rd !== er) begin
            errors++;
            $display("FAIL reset_read0: rdata=%h exp %h slverr=%b exp %b waits=%0d exp %0d setup_ready=%b timeout=%b",
                     rd, er, se, ee, wt, EXP_WAIT, sr, to);
        end
        bus_idle();
    endtask

    task automatic test_write_read();
        op_t ops[$];
        logic [31:0] rd, er; logic se, ee, to, sr; int wt;
        ops.push_back('{wr: 1'b1, addr: 32'h10, data: 32'hDEADBEEF, strb: 4'hF});
        ops.push_back('{wr: 1'b0, addr: 32'h10, data: 32'h0, strb: 4'h0});
        ops.push_back('{wr: 1'b1, addr: 32'h3FC, data: 32'hCAFEF00D, strb: 4'hF});
        ops.push_back('{wr: 1'b0, addr: 32'h3FC, data: 32'h0, strb: 4'h0});
        foreach (ops[k]) begin
            xfer(ops[k], 1'b0, rd, se, wt, to, sr);
            model_xfer(ops[k], er, ee);
            checks++;
            if (to || sr !== 1'b0 || wt != EXP_WAIT || se !== ee || rd !== er) begin
                errors++;
                $display("FAIL write_read[%0d]: rdata=%h exp %h slverr=%b exp %b waits=%0d exp %0d setup_ready=%b timeout=%b",
                         k, rd, er, se, ee, wt, EXP_WAIT, sr, to);
            end
            bus_idle();
        end
    endtask

    task automatic test_partial_strobe();
        op_t op;
        logic [31:0] rd, er; logic se, ee, to, sr; int wt;
        op = '{wr: 1'b1, addr: 32'h10, data: 32'h11223344, strb: 4'b0101};
        xfer(op, 1'b0, rd, se, wt, to, sr);
        model_xfer(op, er, ee);
        bus_idle();
        op = '{wr: 1'b0, addr: 32'h10, data: 32'h0, strb: 4'h0};
        xfer(op, 1'b0, rd, se, wt, to, sr);
        model_xfer(op, er, ee);
        checks++;
        if (to || se !== 1'b0 || rd !== 32'hDE22BE44 || er !== 32'hDE22BE44) begin
            errors++;
            $display("FAIL partial_strobe: rdata=%h slverr=%b timeout=%b, need DE22BE44/0/0",
                     rd, se, to);
        end
        bus_idle();
    endtask

    task automatic test_errors();
        op_t ops[$];
        logic [31:0] rd, er; logic se, ee, to, sr; int wt;
        ops.push_back('{wr: 1'b1, addr: 32'h400, data: 32'h01020304, strb: 4'hF});
        ops.push_back('{wr: 1'b1, addr: 32'h11, data: 32'h55667788, strb: 4'hF});
        ops.push_back('{wr: 1'b0, addr: 32'h10, data: 32'h0, strb: 4'h1});
        ops.push_back('{wr: 1'b0, addr: 32'h10, data: 32'h0, strb: 4'h0});
        ops.push_back('{wr: 1'b0, addr: 32'h0, data: 32'h0, strb: 4'h0});
        ops.push_back('{wr: 1'b0, addr: 32'h400, data: 32'h0, strb: 4'h0});
        ops.push_back('{wr: 1'b1, addr: 32'h10, data: 32'hFFFFFFFF, strb: 4'h0});
        ops.push_back('{wr: 1'b0, addr: 32'h10, data: 32'h0, strb: 4'h0});
        foreach (ops[k]) begin
            xfer(ops[k], 1'b0, rd, se, wt, to, sr);
            model_xfer(ops[k], er, ee);
            checks++;
            if (to || sr !== 1'b0 || wt != EXP_WAIT || se !== ee || rd !== er) begin
                errors++;
                $display("FAIL errors[%0d]: rdata=%h exp %h slverr=%b exp %b waits=%0d exp %0d setup_ready=%b timeout=%b",
                         k, rd, er, se, ee, wt, EXP_WAIT, sr, to);
            end
            bus_idle();
        end
    endtask

    task automatic test_protocol_error();
        op_t op;
        logic [31:0] rd, er; logic se, ee, to, sr; int wt;
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 32'h0; PWDATA = 32'h12345678;
        PSTRB = 4'hF;
        @(negedge PCLK);
        checks++;
        if (PREADY !== 1'b1 || PSLVERR !== 1'b1 || PRDATA !== 32'h0) begin
            errors++;
            $display("FAIL protocol_error: ready=%b slverr=%b rdata=%h, need 1/1/0",
                     PREADY, PSLVERR, PRDATA);
        end
        bus_idle();
        op = '{wr: 1'b0, addr: 32'h0, data: 32'h0, strb: 4'h0};
        xfer(op, 1'b0, rd, se, wt, to, sr);
        model_xfer(op, er, ee);
        checks++;
        if (to || sr !== 1'b0 || wt != EXP_WAIT || se !== ee || rd !== er) begin
            errors++;
            $display("FAIL protocol_recover: rdata=%h exp %h slverr=%b exp %b waits=%0d exp %0d timeout=%b",
                     rd, er, se, ee, wt, EXP_WAIT, to);
        end
        bus_idle();
    endtask

    task automatic test_back_to_back();
        op_t ops[$];
        logic [31:0] rd, er; logic se, ee, to, sr; int wt;
        ops.push_back('{wr: 1'b1, addr: 32'h20, data: 32'hA5A5A5A5, strb: 4'hF});
        ops.push_back('{wr: 1'b1, addr: 32'h24, data: 32'h5A5A5A5A, strb: 4'hF});
        ops.push_back('{wr: 1'b0, addr: 32'h20, data: 32'h0, strb: 4'h0});
        ops.push_back('{wr: 1'b0, addr: 32'h24, data: 32'h0, strb: 4'h0});
        ops.push_back('{wr: 1'b1, addr: 32'h24, data: 32'h0BADF00D, strb: 4'hC});
        ops.push_back('{wr: 1'b0, addr: 32'h24, data: 32'h0, strb: 4'h0});
        foreach (ops[k]) begin
            xfer(ops[k], 1'b0, rd, se, wt, to, sr);
            model_xfer(ops[k], er, ee);
            checks++;
            if (to || sr !== 1'b0 || wt != EXP_WAIT || se !== ee || rd !== er) begin
                errors++;
                $display("FAIL back_to_back[%0d]: rdata=%h exp %h slverr=%b exp %b waits=%0d exp %0d setup_ready=%b timeout=%b",
                         k, rd, er, se, ee, wt, EXP_WAIT, sr, to);
            end
        end
        bus_idle();
    endtask

`ifdef APB_WAIT_STATE_EN
    task automatic test_wait_abort();
        op_t op;
        logic [31:0] rd, er; logic se, ee, to, sr; int wt;
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h40; PWDATA = 32'h77777777;
        PSTRB = 4'hF;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(negedge PCLK);
        checks++;
        if (PREADY !== 1'b0) begin
            errors++;
            $display("FAIL abort_wait_ready: ready=%b, need 0", PREADY);
        end
        bus_idle();
        op = '{wr: 1'b0, addr: 32'h40, data: 32'h0, strb: 4'h0};
        xfer(op, 1'b0, rd, se, wt, to, sr);
        model_xfer(op, er, ee);
        checks++;
        if (to || wt != EXP_WAIT || se !== ee || rd !== er) begin
            errors++;
            $display("FAIL abort_no_write: rdata=%h exp %h slverr=%b exp %b waits=%0d exp %0d timeout=%b",
                     rd, er, se, ee, wt, EXP_WAIT, to);
        end
        bus_idle();
    endtask
`endif

    task automatic test_reset_mid();
        op_t op;
        logic [31:0] rd, er; logic se, ee, to, sr; int wt;
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h30; PWDATA = 32'h12345678;
        PSTRB = 4'hF;
        @(posedge PCLK); #1;
        PENABLE = 1'b1; PRESET = 1'b1;
        @(negedge PCLK);
        checks++;
        if ({PREADY, PSLVERR, PRDATA} !== 34'h0) begin
            errors++;
            $display("FAIL reset_mid_outputs: ready=%b slverr=%b rdata=%h, need 0/0/0",
                     PREADY, PSLVERR, PRDATA);
        end
        @(posedge PCLK); #1;
        PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            op = '{wr: 1'b0, addr: (k == 0) ? 32'h30 : 32'h10, data: 32'h0, strb: 4'h0};
            xfer(op, 1'b0, rd, se, wt, to, sr);
            model_xfer(op, er, ee);
            checks++;
            if (to || wt != EXP_WAIT || se !== ee || rd !== er) begin
                errors++;
                $display("FAIL reset_mid_read[%0d]: rdata=%h exp %h slverr=%b exp %b waits=%0d exp %0d timeout=%b",
                         k, rd, er, se, ee, wt, EXP_WAIT, to);
            end
            bus_idle();
        end
    endtask

    task automatic test_random();
        op_t op;
        logic [31:0] rd, er; logic se, ee, to, sr, scr; int wt;
        int unsigned sel;
        for (int n = 0; n < 80; n++) begin
            sel     = $urandom_range(0, 9);
            op.wr   = 1'($urandom_range(0, 1));
            op.data = $urandom;
            op.strb = 4'($urandom);
            if (sel <= 6)      op.addr = 32'($urandom_range(0, 15)) << 2;
            else if (sel == 7) op.addr = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
            else if (sel == 8) op.addr = 32'h400 + (32'($urandom_range(0, 255)) << 2);
            else               op.addr = 32'h3FC;
            if (!op.wr && $urandom_range(0, 4) != 0) op.strb = 4'h0;
            scr = 1'($urandom_range(0, 1));
            xfer(op, scr, rd, se, wt, to, sr);
            model_xfer(op, er, ee);
            checks++;
            if (to || sr !== 1'b0 || wt != EXP_WAIT || se !== ee || rd !== er) begin
                errors++;
                $display("FAIL random[%0d] wr=%b addr=%h strb=%h: rdata=%h exp %h slverr=%b exp %b waits=%0d exp %0d timeout=%b",
                         n, op.wr, op.addr, op.strb, rd, er, se, ee, wt, EXP_WAIT, to);
            end
            if ($urandom_range(0, 1) == 0) bus_idle();
        end
        bus_idle();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_partial_strobe();
        test_errors();
        test_protocol_error();
        test_back_to_back();
`ifdef APB_WAIT_STATE_EN
        test_wait_abort();
`endif
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
